// File: rtl/fu_alu_pipe.sv
// fu_alu_pipe: pipelined integer ALU functional unit for the execute stage.
// Result and flags are computed at the input and registered into stage 1.
// Stages 2..STAGES are plain delay registers. The last stage drives the
// writeback (CDB/ROB arbiter) handshake. A stall freezes the whole pipe,
// including empty stages. A flush clears every stage valid.
module fu_alu_pipe #(
    parameter int WIDTH        = 16,
    parameter int STAGES       = 2,
    parameter int ROB_ENTRY    = 16,
    parameter int NUM_PHYS_REG = 32
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            flush_i,
    input  logic                            exe_v_i,
    output logic                            exe_ready_o,
    input  logic                            w_v_i,
    input  logic [2:0]                      opcode_i,
    input  logic [WIDTH-1:0]                operand1_i,
    input  logic [WIDTH-1:0]                operand2_i,
    input  logic [$clog2(ROB_ENTRY)-1:0]    rob_dest_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0] reg_dest_i,
    input  logic                            cdb_ready_i,
    output logic                            out_v_o,
    output logic                            out_w_v_o,
    output logic [$clog2(ROB_ENTRY)-1:0]    out_rob_dest_o,
    output logic [$clog2(NUM_PHYS_REG)-1:0] out_reg_dest_o,
    output logic [WIDTH-1:0]                out_result_o,
    output logic [3:0]                      out_flags_o
);

    localparam int TAG_W = $clog2(ROB_ENTRY);
    localparam int REG_W = $clog2(NUM_PHYS_REG);
    localparam int SH_W  = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_SAR = 3'd7;

    // ------------------------------------------------------------------
    // ALU datapath
    // ------------------------------------------------------------------
    logic                    is_sub;
    logic [WIDTH-1:0]        add_b;
    logic [WIDTH:0]          add_sum;
    logic [SH_W-1:0]         sh_amt;
    // Shifts are done one bit wider so the extra bit catches the last bit
    // shifted out; with a zero amount that bit is naturally 0.
    logic [WIDTH:0]          shl_ext;
    logic [WIDTH:0]          shr_ext;
    logic signed [WIDTH:0]   sar_in;
    logic signed [WIDTH:0]   sar_ext;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_c;
    logic                    alu_v;
    logic [3:0]              alu_flags;

    // SUB shares the adder as op1 + ~op2 + 1, so C=1 means no borrow.
    assign is_sub  = (opcode_i == OP_SUB);
    assign add_b   = is_sub ? ~operand2_i : operand2_i;
    assign add_sum = {1'b0, operand1_i} + {1'b0, add_b} + {{WIDTH{1'b0}}, is_sub};

    assign sh_amt  = operand2_i[SH_W-1:0];
    assign shl_ext = {1'b0, operand1_i} << sh_amt;
    assign shr_ext = {operand1_i, 1'b0} >> sh_amt;
    assign sar_in  = {operand1_i, 1'b0};
    assign sar_ext = sar_in >>> sh_amt;

    // Opcode select for result, carry and overflow.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opcode_i)
            OP_ADD, OP_SUB: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (operand1_i[WIDTH-1] == add_b[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != operand1_i[WIDTH-1]);
            end
            OP_AND: alu_res = operand1_i & operand2_i;
            OP_OR:  alu_res = operand1_i | operand2_i;
            OP_XOR: alu_res = operand1_i ^ operand2_i;
            OP_SHL: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            OP_SAR: begin
                alu_res = sar_ext[WIDTH:1];
                alu_c   = sar_ext[0];
            end
            default: ;
        endcase
    end

    assign alu_flags = {(alu_res == '0), alu_res[WIDTH-1], alu_c, alu_v};

    // ------------------------------------------------------------------
    // Pipeline stages 1..STAGES
    // ------------------------------------------------------------------
    logic [STAGES:1]             vld_q,   vld_d;
    logic [STAGES:1]             wv_q,    wv_d;
    logic [STAGES:1][TAG_W-1:0]  rob_q,   rob_d;
    logic [STAGES:1][REG_W-1:0]  reg_q,   reg_d;
    logic [STAGES:1][WIDTH-1:0]  res_q,   res_d;
    logic [STAGES:1][3:0]        flg_q,   flg_d;

    logic stall;
    logic accept;

    assign stall       = vld_q[STAGES] & ~cdb_ready_i;
    assign exe_ready_o = ~stall;
    assign accept      = exe_v_i & exe_ready_o & ~flush_i;

    // Stage 1 captures the ALU output; data loads whenever the pipe moves,
    // since the valid bit alone decides whether it means anything.
    assign vld_d[1] = ~flush_i & (stall ? vld_q[1] : accept);
    assign wv_d[1]  = stall ? wv_q[1]  : w_v_i;
    assign rob_d[1] = stall ? rob_q[1] : rob_dest_i;
    assign reg_d[1] = stall ? reg_q[1] : reg_dest_i;
    assign res_d[1] = stall ? res_q[1] : alu_res;
    assign flg_d[1] = stall ? flg_q[1] : alu_flags;

    // Delay stages: hold on stall, otherwise take the previous stage.
    for (genvar s = 2; s <= STAGES; s++) begin : g_stage
        assign vld_d[s] = ~flush_i & (stall ? vld_q[s] : vld_q[s-1]);
        assign wv_d[s]  = stall ? wv_q[s]  : wv_q[s-1];
        assign rob_d[s] = stall ? rob_q[s] : rob_q[s-1];
        assign reg_d[s] = stall ? reg_q[s] : reg_q[s-1];
        assign res_d[s] = stall ? res_q[s] : res_q[s-1];
        assign flg_d[s] = stall ? flg_q[s] : flg_q[s-1];
    end

    // Stage registers; async reset clears valids and data so outputs read 0.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vld_q <= '0;
            wv_q  <= '0;
            rob_q <= '0;
            reg_q <= '0;
            res_q <= '0;
            flg_q <= '0;
        end else begin
            vld_q <= vld_d;
            wv_q  <= wv_d;
            rob_q <= rob_d;
            reg_q <= reg_d;
            res_q <= res_d;
            flg_q <= flg_d;
        end
    end

    // ------------------------------------------------------------------
    // Output stage drives the writeback handshake directly
    // ------------------------------------------------------------------
    assign out_v_o        = vld_q[STAGES];
    assign out_w_v_o      = vld_q[STAGES] & wv_q[STAGES];
    assign out_rob_dest_o = rob_q[STAGES];
    assign out_reg_dest_o = reg_q[STAGES];
    assign out_result_o   = res_q[STAGES];
    assign out_flags_o    = flg_q[STAGES];

endmodule

// File: tb/tb_fu_alu_pipe.sv
// Testbench for fu_alu_pipe: directed scenarios plus randomized traffic,
// checked every cycle against an in-order latency model of the unit.
module tb_fu_alu_pipe;

    localparam int W   = 16;
    localparam int STG = 2;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        exe_v_i;
    logic        exe_ready_o;
    logic        w_v_i;
    logic [2:0]  opcode_i;
    logic [15:0] operand1_i;
    logic [15:0] operand2_i;
    logic [3:0]  rob_dest_i;
    logic [4:0]  reg_dest_i;
    logic        cdb_ready_i;
    logic        out_v_o;
    logic        out_w_v_o;
    logic [3:0]  out_rob_dest_o;
    logic [4:0]  out_reg_dest_o;
    logic [15:0] out_result_o;
    logic [3:0]  out_flags_o;

    always #5 clk_i = ~clk_i;

    fu_alu_pipe #(
        .WIDTH(W), .STAGES(STG), .ROB_ENTRY(16), .NUM_PHYS_REG(32)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .exe_v_i(exe_v_i), .exe_ready_o(exe_ready_o), .w_v_i(w_v_i),
        .opcode_i(opcode_i), .operand1_i(operand1_i), .operand2_i(operand2_i),
        .rob_dest_i(rob_dest_i), .reg_dest_i(reg_dest_i),
        .cdb_ready_i(cdb_ready_i), .out_v_o(out_v_o), .out_w_v_o(out_w_v_o),
        .out_rob_dest_o(out_rob_dest_o), .out_reg_dest_o(out_reg_dest_o),
        .out_result_o(out_result_o), .out_flags_o(out_flags_o)
    );

    int checks = 0;
    int errors = 0;
    int consumed = 0;
    int ready_low = 0;

    // In-flight op: expected writeback fields plus how many edges it has
    // spent in the pipe; it sits at the output once that reaches STG.
    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        logic [3:0]  rob;
        logic [4:0]  rg;
        logic        wv;
        int          cnt;
    } ent_t;
    ent_t q[$];

    logic        smp_v, smp_wv;
    logic [15:0] smp_res;
    logic [3:0]  smp_flg, smp_rob;
    logic [4:0]  smp_rg;

    // Reference ALU from plain integer arithmetic.
    function automatic void alu_ref(input logic [2:0] op, input logic [15:0] a,
                                    input logic [15:0] b, output logic [15:0] r,
                                    output logic [3:0] f);
        int ua, ub, sa, sb, t, amt;
        bit c, v;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        amt = ub % W;
        c = 0; v = 0; t = 0;
        case (op)
            3'd0: begin t = ua + ub; c = (t > 65535);
                        v = ((sa + sb) > 32767) || ((sa + sb) < -32768); end
            3'd1: begin t = ua - ub; c = (ua >= ub);
                        v = ((sa - sb) > 32767) || ((sa - sb) < -32768); end
            3'd2: t = ua & ub;
            3'd3: t = ua | ub;
            3'd4: t = ua ^ ub;
            3'd5: begin t = ua << amt; c = (amt != 0) && (((ua >> (W - amt)) & 1) == 1); end
            3'd6: begin t = ua >> amt; c = (amt != 0) && (((ua >> (amt - 1)) & 1) == 1); end
            default: begin t = sa >>> amt; c = (amt != 0) && (((sa >>> (amt - 1)) & 1) == 1); end
        endcase
        r = t[15:0];
        f = {(r == 16'h0), r[15], c, v};
    endfunction

    // One clock cycle: drive on the falling edge, check against the model,
    // then advance the model across the rising edge.
    task automatic cycle(input bit ev, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] rob,
                         input logic [4:0] rg, input bit wv, input bit rdy,
                         input bit fl, output bit acc);
        bit exp_v, exp_rdy;
        ent_t e;
        @(negedge clk_i);
        exe_v_i = ev; opcode_i = op; operand1_i = a; operand2_i = b;
        rob_dest_i = rob; reg_dest_i = rg; w_v_i = wv;
        cdb_ready_i = rdy; flush_i = fl;
        #1;
        exp_v   = (q.size() > 0) && (q[0].cnt == STG);
        exp_rdy = !(exp_v && !rdy);
        checks++;
        if (out_v_o !== exp_v) begin
            errors++; $display("FAIL out_v got %0b expected %0b t=%0t", out_v_o, exp_v, $time);
        end
        checks++;
        if (exe_ready_o !== exp_rdy) begin
            errors++; $display("FAIL exe_ready got %0b expected %0b t=%0t", exe_ready_o, exp_rdy, $time);
        end
        if (exp_v) begin
            checks++;
            if ({out_result_o, out_flags_o, out_rob_dest_o, out_reg_dest_o, out_w_v_o} !==
                {q[0].res, q[0].flg, q[0].rob, q[0].rg, q[0].wv}) begin
                errors++;
                $display("FAIL out_data got res=%h flg=%b rob=%0d reg=%0d wv=%0b expected res=%h flg=%b rob=%0d reg=%0d wv=%0b t=%0t",
                         out_result_o, out_flags_o, out_rob_dest_o, out_reg_dest_o, out_w_v_o,
                         q[0].res, q[0].flg, q[0].rob, q[0].rg, q[0].wv, $time);
            end
        end else begin
            checks++;
            if (out_w_v_o !== 1'b0) begin
                errors++; $display("FAIL out_w_v_idle got %0b expected 0 t=%0t", out_w_v_o, $time);
            end
        end
        smp_v = out_v_o; smp_wv = out_w_v_o; smp_res = out_result_o;
        smp_flg = out_flags_o; smp_rob = out_rob_dest_o; smp_rg = out_reg_dest_o;
        if (out_v_o === 1'b1 && rdy) consumed++;
        if (exe_ready_o === 1'b0) ready_low++;
        acc = ev && exp_rdy && !fl;
        @(posedge clk_i);
        if (fl) q.delete();
        else if (exp_rdy) begin
            if (exp_v) void'(q.pop_front());
            foreach (q[i]) q[i].cnt++;
            if (ev) begin
                alu_ref(op, a, b, e.res, e.flg);
                e.rob = rob; e.rg = rg; e.wv = wv; e.cnt = 1;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(0, 3'd0, 16'h0, 16'h0, 4'd0, 5'd0, 0, 1, 0, acc);
    endtask

    task automatic test_reset();
        reset_i = 1; flush_i = 0; exe_v_i = 0; w_v_i = 0; opcode_i = 0;
        operand1_i = 0; operand2_i = 0; rob_dest_i = 0; reg_dest_i = 0; cdb_ready_i = 1;
        repeat (2) @(negedge clk_i);
        reset_i = 0;
        q.delete();
        #1;
        checks++;
        if (out_v_o !== 1'b0 || out_w_v_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid got v=%0b wv=%0b expected 0/0", out_v_o, out_w_v_o);
        end
        checks++;
        if (out_result_o !== 16'h0 || out_flags_o !== 4'h0 || out_rob_dest_o !== 4'h0 || out_reg_dest_o !== 5'h0) begin
            errors++; $display("FAIL reset_data got res=%h flg=%b rob=%0d reg=%0d expected zeros",
                               out_result_o, out_flags_o, out_rob_dest_o, out_reg_dest_o);
        end
        checks++;
        if (exe_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %0b expected 1", exe_ready_o);
        end
    endtask

    task automatic test_sanity();
        bit acc;
        cycle(1, 3'd0, 16'h0003, 16'h0004, 4'd5, 5'd9, 1, 1, 0, acc);
        idle(STG);
        checks++;
        if (!(smp_v === 1'b1 && smp_res === 16'h0007 && smp_flg === 4'b0000 &&
              smp_rob === 4'd5 && smp_rg === 5'd9 && smp_wv === 1'b1)) begin
            errors++;
            $display("FAIL sanity got v=%0b res=%h flg=%b rob=%0d reg=%0d wv=%0b expected 1 0007 0000 5 9 1",
                     smp_v, smp_res, smp_flg, smp_rob, smp_rg, smp_wv);
        end
    endtask

    task automatic test_flags();
        bit acc;
        logic [2:0] op; logic [15:0] a, b, er; logic [3:0] ef;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin op = 3'd0; a = 16'h7FFF; b = 16'h0001; er = 16'h8000; ef = 4'b0101; end
                1: begin op = 3'd1; a = 16'h0005; b = 16'h0005; er = 16'h0000; ef = 4'b1010; end
                default: begin op = 3'd1; a = 16'h0000; b = 16'h0001; er = 16'hFFFF; ef = 4'b0100; end
            endcase
            cycle(1, op, a, b, 4'(i), 5'(i), 0, 1, 0, acc);
            idle(STG);
            checks++;
            if (smp_v !== 1'b1 || smp_res !== er || smp_flg !== ef) begin
                errors++; $display("FAIL flags_%0d got v=%0b res=%h flg=%b expected res=%h flg=%b",
                                   i, smp_v, smp_res, smp_flg, er, ef);
            end
        end
    endtask

    task automatic test_shifts();
        bit acc;
        logic [2:0] op; logic [15:0] a, b, er; logic [3:0] ef;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin op = 3'd5; a = 16'h8001; b = 16'h0001; er = 16'h0002; ef = 4'b0010; end
                1: begin op = 3'd7; a = 16'h8000; b = 16'h0013; er = 16'hF000; ef = 4'b0100; end
                default: begin op = 3'd6; a = 16'h1234; b = 16'h0000; er = 16'h1234; ef = 4'b0000; end
            endcase
            cycle(1, op, a, b, 4'd3, 5'd7, 1, 1, 0, acc);
            idle(STG);
            checks++;
            if (smp_v !== 1'b1 || smp_res !== er || smp_flg !== ef) begin
                errors++; $display("FAIL shift_%0d got v=%0b res=%h flg=%b expected res=%h flg=%b",
                                   i, smp_v, smp_res, smp_flg, er, ef);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit acc, started;
        int issued, stall_left;
        logic [15:0] a [4];
        for (int i = 0; i < 4; i++) a[i] = 16'($urandom);
        issued = 0; started = 0; stall_left = 0; consumed = 0; ready_low = 0;
        for (int c = 0; c < 40 && (issued < 4 || q.size() > 0); c++) begin
            if (!started && q.size() > 0 && q[0].cnt == STG) begin
                started = 1; stall_left = 3;
            end
            cycle(issued < 4, 3'd0, a[issued % 4], 16'(issued + 1), 4'(issued + 8),
                  5'(issued + 20), 1, stall_left == 0, 0, acc);
            if (stall_left > 0) stall_left--;
            if (acc) issued++;
        end
        checks++;
        if (consumed != 4) begin
            errors++; $display("FAIL b2b_count got %0d ops expected 4", consumed);
        end
        checks++;
        if (ready_low != 3) begin
            errors++; $display("FAIL b2b_ready_low got %0d cycles expected 3", ready_low);
        end
    endtask

    task automatic test_flush();
        bit acc;
        int seen;
        cycle(1, 3'd0, 16'h0001, 16'h0001, 4'd1, 5'd1, 1, 1, 0, acc);
        cycle(1, 3'd0, 16'h0002, 16'h0002, 4'd2, 5'd2, 1, 1, 0, acc);
        consumed = 0;
        cycle(1, 3'd0, 16'h0003, 16'h0003, 4'd3, 5'd3, 1, 0, 1, acc);
        seen = 0;
        for (int i = 0; i < STG + 2; i++) begin
            idle(1);
            if (smp_v !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || consumed != 0) begin
            errors++; $display("FAIL flush_kill got %0d valid cycles %0d consumed expected 0/0", seen, consumed);
        end
        cycle(1, 3'd4, 16'h00FF, 16'h0F0F, 4'd4, 5'd4, 1, 1, 0, acc);
        idle(STG);
        checks++;
        if (smp_v !== 1'b1 || smp_res !== 16'h0FF0 || smp_flg !== 4'b0000 || smp_rob !== 4'd4) begin
            errors++; $display("FAIL flush_after got v=%0b res=%h flg=%b rob=%0d expected 1 0ff0 0000 4",
                               smp_v, smp_res, smp_flg, smp_rob);
        end
    endtask

    task automatic test_async_reset();
        bit acc;
        cycle(1, 3'd0, 16'h1111, 16'h2222, 4'd6, 5'd6, 1, 1, 0, acc);
        cycle(1, 3'd0, 16'h3333, 16'h4444, 4'd7, 5'd7, 1, 1, 0, acc);
        @(negedge clk_i);
        exe_v_i = 0; cdb_ready_i = 0; flush_i = 0;
        #1;
        checks++;
        if (out_v_o !== 1'b1 || out_result_o !== 16'h3333) begin
            errors++; $display("FAIL pre_reset got v=%0b res=%h expected 1 3333", out_v_o, out_result_o);
        end
        #1 reset_i = 1;
        #1;
        checks++;
        if (out_v_o !== 1'b0 || out_w_v_o !== 1'b0 || out_result_o !== 16'h0 || out_flags_o !== 4'h0 ||
            out_rob_dest_o !== 4'h0 || out_reg_dest_o !== 5'h0 || exe_ready_o !== 1'b1) begin
            errors++; $display("FAIL async_reset got v=%0b wv=%0b res=%h flg=%b rob=%0d reg=%0d rdy=%0b expected 0 0 0000 0000 0 0 1",
                               out_v_o, out_w_v_o, out_result_o, out_flags_o, out_rob_dest_o, out_reg_dest_o, exe_ready_o);
        end
        q.delete();
        #1 reset_i = 0;
        @(posedge clk_i);
        cycle(1, 3'd1, 16'h0000, 16'h0001, 4'd9, 5'd9, 1, 1, 0, acc);
        idle(STG);
        checks++;
        if (smp_v !== 1'b1 || smp_res !== 16'hFFFF || smp_flg !== 4'b0100) begin
            errors++; $display("FAIL post_reset got v=%0b res=%h flg=%b expected 1 ffff 0100", smp_v, smp_res, smp_flg);
        end
    endtask

    function automatic logic [15:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_random();
        bit acc;
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 9) < 7, 3'($urandom), rnd_operand(), rnd_operand(),
                  4'($urandom), 5'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, acc);
        idle(STG + 4);
    endtask

    initial begin
        test_reset();
        test_sanity();
        test_flags();
        test_shifts();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout reached without completing the run");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
